// File: rtl/proj_pool_if.sv
// -----------------------------------------------------------------------------
// proj_pool_if
// Bundle between one projectile pool and its neighbours (controller,
// collision checker, renderer).
//   master : controller side - drives pulse_projSpeed, shoot, hit_vec and the
//            shooter geometry (playerX/playerY/playerW); reads the pool state.
//   slave  : the pool itself - the mirror image of master.
// Packed coordinates: slot i at proj_x[i*X_W +: X_W], proj_y[i*Y_W +: Y_W].
// -----------------------------------------------------------------------------
interface proj_pool_if #(
  parameter int N_PROJ = 3,
  parameter int X_W    = 10,
  parameter int Y_W    = 9
);
  logic                    pulse_projSpeed;
  logic                    shoot;
  logic [N_PROJ-1:0]       hit_vec;
  logic [X_W-1:0]          playerX;
  logic [Y_W-1:0]          playerY;
  logic [X_W-1:0]          playerW;
  logic [N_PROJ*X_W-1:0]   proj_x;
  logic [N_PROJ*Y_W-1:0]   proj_y;
  logic [N_PROJ-1:0]       proj_active;
  logic                    shot_fired;
  logic                    shot_blocked;
  logic                    pool_full;

  modport master (
    output pulse_projSpeed, shoot, hit_vec, playerX, playerY, playerW,
    input  proj_x, proj_y, proj_active, shot_fired, shot_blocked, pool_full
  );

  modport slave (
    input  pulse_projSpeed, shoot, hit_vec, playerX, playerY, playerW,
    output proj_x, proj_y, proj_active, shot_fired, shot_blocked, pool_full
  );
endinterface

// File: rtl/proj_pool.sv
// -----------------------------------------------------------------------------
// proj_pool
// Projectile pool for one shooter. Spawns a projectile at the shooter's centre
// on a rising shoot edge (subject to a cooldown counted in speed pulses and a
// free slot), moves every live projectile STEP pixels per speed pulse, and
// retires projectiles on a collision hit or when they leave the play field.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : proj_pool_if.slave - controls in, packed projectile state out
// All outputs are registered (pool_full is a reduction of registered flags).
// -----------------------------------------------------------------------------
module proj_pool #(
  parameter int N_PROJ   = 3,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int STEP     = 4,
  parameter bit DIR_UP   = 1'b1,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int X_MAX    = 639,
  parameter int COOLDOWN = 2
) (
  input  logic           clk,
  input  logic           rst,
  proj_pool_if.slave     bus
);

  localparam int CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int SLOT_W = (N_PROJ > 1) ? $clog2(N_PROJ) : 1;

  // Bounds widened by one bit so sums/differences cannot wrap before compare.
  localparam logic [X_W:0] X_SAT  = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0] Y_LO   = (Y_W+1)'(Y_MIN + STEP);
  localparam logic [Y_W:0] Y_HI   = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] STEP_W = (Y_W+1)'(STEP);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  logic [N_PROJ-1:0] active_q, active_d;
  logic [X_W-1:0]    x_q [N_PROJ];
  logic [X_W-1:0]    x_d [N_PROJ];
  logic [Y_W-1:0]    y_q [N_PROJ];
  logic [Y_W-1:0]    y_d [N_PROJ];
  logic [CD_W-1:0]   cooldown_q, cooldown_d;
  logic              shoot_prev_q;
  logic              fired_q, fired_d;
  logic              blocked_q, blocked_d;

  logic              fire_req;
  logic              free_found;
  logic [SLOT_W-1:0] free_idx;
  logic              spawn;
  logic [X_W:0]      spawn_x_wide;
  logic [X_W-1:0]    spawn_x;
  logic [Y_W:0]      y_wide;
  logic [Y_W:0]      y_moved;

  // Spawn decision: lowest free slot judged on pre-cycle state, so a slot
  // freed this cycle only becomes eligible on the next one.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a variable unassigned would otherwise infer a latch.
    fire_req   = bus.shoot & ~shoot_prev_q;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_PROJ - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
    spawn        = fire_req && (cooldown_q == '0) && free_found;
    spawn_x_wide = {1'b0, bus.playerX} + ({1'b0, bus.playerW} >> 1);
    spawn_x      = (spawn_x_wide > X_SAT) ? X_SAT[X_W-1:0] : spawn_x_wide[X_W-1:0];
  end

  // Per-slot next state. Priority: spawn (slot is inactive, so nothing else
  // can apply), then hit, then movement/edge retire.
  always_comb begin
    active_d = active_q;
    y_wide   = '0;
    y_moved  = '0;
    for (int i = 0; i < N_PROJ; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      if (spawn && (free_idx == SLOT_W'(i))) begin
        active_d[i] = 1'b1;
        x_d[i]      = spawn_x;
        y_d[i]      = bus.playerY;
      end else if (active_q[i]) begin
        y_wide = {1'b0, y_q[i]};
        if (bus.hit_vec[i]) begin
          active_d[i] = 1'b0;
          x_d[i]      = '0;
          y_d[i]      = '0;
        end else if (bus.pulse_projSpeed) begin
          if (DIR_UP) begin
            y_moved = y_wide - STEP_W;
            if (y_wide < Y_LO) begin
              active_d[i] = 1'b0;
              x_d[i]      = '0;
              y_d[i]      = '0;
            end else begin
              y_d[i] = y_moved[Y_W-1:0];
            end
          end else begin
            y_moved = y_wide + STEP_W;
            if (y_moved > Y_HI) begin
              active_d[i] = 1'b0;
              x_d[i]      = '0;
              y_d[i]      = '0;
            end else begin
              y_d[i] = y_moved[Y_W-1:0];
            end
          end
        end
      end
    end
  end

  // Cooldown reloads on an accepted shot and otherwise counts speed pulses.
  always_comb begin
    cooldown_d = cooldown_q;
    if (spawn) begin
      cooldown_d = CD_LOAD;
    end else if (bus.pulse_projSpeed && (cooldown_q != '0)) begin
      cooldown_d = cooldown_q - 1'b1;
    end
    fired_d   = spawn;
    blocked_d = fire_req && !spawn;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst) begin
      active_q     <= '0;
      cooldown_q   <= '0;
      fired_q      <= 1'b0;
      blocked_q    <= 1'b0;
      // Treat shoot as already high so a press held through reset is ignored.
      shoot_prev_q <= 1'b1;
      // NOTE: the slot coordinate arrays are reset too, because an inactive
      // slot must read x=0, y=0 to the renderer immediately after reset.
      for (int i = 0; i < N_PROJ; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      active_q     <= active_d;
      cooldown_q   <= cooldown_d;
      fired_q      <= fired_d;
      blocked_q    <= blocked_d;
      shoot_prev_q <= bus.shoot;
      for (int i = 0; i < N_PROJ; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_PROJ; g++) begin : g_pack
    assign bus.proj_x[g*X_W +: X_W] = x_q[g];
    assign bus.proj_y[g*Y_W +: Y_W] = y_q[g];
  end

  assign bus.proj_active  = active_q;
  assign bus.shot_fired   = fired_q;
  assign bus.shot_blocked = blocked_q;
  assign bus.pool_full    = &active_q;

endmodule

// File: tb/tb_proj_pool.sv
// -----------------------------------------------------------------------------
// tb_proj_pool
// Directed bench for proj_pool: one upward-moving pool (player) with default
// parameters and one downward-moving pool (enemy, DIR_UP=0). Inputs change 1ns
// after a rising edge; outputs are sampled 1ns after the following edge.
// -----------------------------------------------------------------------------
module tb_proj_pool;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  proj_pool_if #(.N_PROJ(3), .X_W(10), .Y_W(9)) ifa ();
  proj_pool_if #(.N_PROJ(3), .X_W(10), .Y_W(9)) ifb ();

  proj_pool #(.DIR_UP(1'b1)) u_up (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  proj_pool #(.DIR_UP(1'b0)) u_dn (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    ifa.pulse_projSpeed = 1'b0; ifa.shoot = 1'b0; ifa.hit_vec = '0;
    ifa.playerX = 10'd449; ifa.playerY = 9'd450; ifa.playerW = 10'd30;
    ifb.pulse_projSpeed = 1'b0; ifb.shoot = 1'b0; ifb.hit_vec = '0;
    ifb.playerX = 10'd10;  ifb.playerY = 9'd475; ifb.playerW = 10'd10;

    // Reset
    rst = 1'b0; cyc(); cyc();
    rst = 1'b1;
    check("rst_active", 32'(ifa.proj_active), 32'd0);
    check("rst_x",      32'(ifa.proj_x), 32'd0);
    check("rst_y",      32'(ifa.proj_y), 32'd0);
    check("rst_fired",  32'(ifa.shot_fired), 32'd0);
    check("rst_full",   32'(ifa.pool_full), 32'd0);
    cyc();

    // Spawn and move
    ifa.shoot = 1'b1; cyc();
    check("spawn_active", 32'(ifa.proj_active), 32'b001);
    check("spawn_x0",     32'(ifa.proj_x[9:0]), 32'd464);
    check("spawn_y0",     32'(ifa.proj_y[8:0]), 32'd450);
    check("spawn_fired",  32'(ifa.shot_fired), 32'd1);
    cyc();
    check("hold_fired",   32'(ifa.shot_fired), 32'd0);
    check("hold_active",  32'(ifa.proj_active), 32'b001);
    ifa.pulse_projSpeed = 1'b1; cyc(); ifa.pulse_projSpeed = 1'b0;
    check("move_y0",      32'(ifa.proj_y[8:0]), 32'd446);

    // Cooldown: one pulse elapsed, edge is rejected
    ifa.shoot = 1'b0; cyc();
    ifa.shoot = 1'b1; cyc();
    check("cd_blocked",   32'(ifa.shot_blocked), 32'd1);
    check("cd_active",    32'(ifa.proj_active), 32'b001);
    ifa.shoot = 1'b0; ifa.pulse_projSpeed = 1'b1; cyc(); ifa.pulse_projSpeed = 1'b0;
    check("cd_blk_pulse", 32'(ifa.shot_blocked), 32'd0);
    ifa.shoot = 1'b1; cyc();
    check("cd_fire",      32'(ifa.shot_fired), 32'd1);
    check("cd_active2",   32'(ifa.proj_active), 32'b011);
    check("cd_x1",        32'(ifa.proj_x[19:10]), 32'd464);
    check("cd_y0",        32'(ifa.proj_y[8:0]), 32'd442);
    ifa.shoot = 1'b0; cyc();

    // Fill the pool
    ifa.pulse_projSpeed = 1'b1; cyc(); cyc(); ifa.pulse_projSpeed = 1'b0;
    ifa.shoot = 1'b1; cyc(); ifa.shoot = 1'b0;
    check("full_active",  32'(ifa.proj_active), 32'b111);
    check("full_flag",    32'(ifa.pool_full), 32'd1);
    check("full_y2",      32'(ifa.proj_y[26:18]), 32'd450);
    ifa.pulse_projSpeed = 1'b1; cyc(); cyc(); ifa.pulse_projSpeed = 1'b0;
    check("full_y_moved", 32'(ifa.proj_y), 32'({9'd442, 9'd434, 9'd426}));
    ifa.shoot = 1'b1; cyc(); ifa.shoot = 1'b0;
    check("full_blocked", 32'(ifa.shot_blocked), 32'd1);
    check("full_nofire",  32'(ifa.shot_fired), 32'd0);
    check("full_same_y",  32'(ifa.proj_y), 32'({9'd442, 9'd434, 9'd426}));
    cyc();

    // Hit slot1 with a pulse: hit wins over move, others move
    ifa.hit_vec = 3'b010; ifa.pulse_projSpeed = 1'b1; cyc();
    ifa.hit_vec = 3'b000; ifa.pulse_projSpeed = 1'b0;
    check("hit_active",   32'(ifa.proj_active), 32'b101);
    check("hit_x1",       32'(ifa.proj_x[19:10]), 32'd0);
    check("hit_y",        32'(ifa.proj_y), 32'({9'd438, 9'd0, 9'd422}));
    check("hit_full",     32'(ifa.pool_full), 32'd0);

    // Reuse slot1; spawn with pulse high must not move the new slot
    ifa.playerX = 10'd100; ifa.playerW = 10'd20; ifa.playerY = 9'd200;
    ifa.shoot = 1'b1; ifa.pulse_projSpeed = 1'b1; cyc();
    ifa.shoot = 1'b0; ifa.pulse_projSpeed = 1'b0;
    check("reuse_active", 32'(ifa.proj_active), 32'b111);
    check("reuse_x1",     32'(ifa.proj_x[19:10]), 32'd110);
    check("reuse_y",      32'(ifa.proj_y), 32'({9'd434, 9'd200, 9'd418}));

    // Reset mid-flight with shoot held high, then release
    ifa.shoot = 1'b1; rst = 1'b0; cyc();
    check("mrst_active",  32'(ifa.proj_active), 32'd0);
    check("mrst_x",       32'(ifa.proj_x), 32'd0);
    check("mrst_y",       32'(ifa.proj_y), 32'd0);
    rst = 1'b1; cyc();
    check("mrst_nofire",  32'(ifa.shot_fired), 32'd0);
    check("mrst_idle",    32'(ifa.proj_active), 32'd0);
    ifa.shoot = 1'b0; cyc();

    // Top edge retire: y=3 retires on the next pulse
    ifa.playerX = 10'd0; ifa.playerW = 10'd0; ifa.playerY = 9'd3;
    ifa.shoot = 1'b1; cyc(); ifa.shoot = 1'b0;
    check("top_y0",       32'(ifa.proj_y[8:0]), 32'd3);
    ifa.pulse_projSpeed = 1'b1; cyc();
    check("top_retire",   32'(ifa.proj_active), 32'd0);
    check("top_retire_y", 32'(ifa.proj_y), 32'd0);
    cyc(); ifa.pulse_projSpeed = 1'b0;

    // X saturation, then y=4 moves to 0 and stays live, next pulse retires
    ifa.playerX = 10'd630; ifa.playerW = 10'd30; ifa.playerY = 9'd4;
    ifa.shoot = 1'b1; cyc(); ifa.shoot = 1'b0;
    check("sat_fired",    32'(ifa.shot_fired), 32'd1);
    check("sat_x0",       32'(ifa.proj_x[9:0]), 32'd639);
    ifa.pulse_projSpeed = 1'b1; cyc();
    check("y4_live",      32'(ifa.proj_active), 32'b001);
    check("y4_at0",       32'(ifa.proj_y[8:0]), 32'd0);
    cyc(); ifa.pulse_projSpeed = 1'b0;
    check("y0_retire",    32'(ifa.proj_active), 32'd0);
    check("y0_retire_x",  32'(ifa.proj_x), 32'd0);

    // Downward pool: 475 -> 479 (live) -> 483 > 479 retire
    ifb.shoot = 1'b1; cyc(); ifb.shoot = 1'b0;
    check("dn_spawn_x",   32'(ifb.proj_x[9:0]), 32'd15);
    check("dn_spawn_y",   32'(ifb.proj_y[8:0]), 32'd475);
    ifb.hit_vec = 3'b110; cyc(); ifb.hit_vec = 3'b000;
    check("dn_hit_idle",  32'(ifb.proj_active), 32'b001);
    ifb.pulse_projSpeed = 1'b1; cyc();
    check("dn_y479",      32'(ifb.proj_y[8:0]), 32'd479);
    check("dn_live",      32'(ifb.proj_active), 32'b001);
    cyc(); ifb.pulse_projSpeed = 1'b0;
    check("dn_retire",    32'(ifb.proj_active), 32'd0);
    check("dn_retire_y",  32'(ifb.proj_y), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proj_pool.md
# proj_pool

Parametrised projectile pool for the game datapath: owns up to N_PROJ projectiles for one shooter (player or enemy). It spawns a projectile at the shooter's centre on a shoot edge, advances every live projectile on each speed pulse, and retires projectiles on a hit or at the screen edge. All projectile state is held internally. It sits between the input/controller logic, the collision checker (which returns a hit vector) and the VGA renderer (which reads the packed coordinates).

## Interface
Parameters:
- N_PROJ, 3, number of projectile slots (1..8)
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width
- STEP, 4, pixels moved per speed pulse
- DIR_UP, 1, 1 = move toward y=0 (player); 0 = toward Y_MAX (enemy)
- Y_MIN, 0, top retire bound
- Y_MAX, 479, bottom retire bound
- X_MAX, 639, spawn x saturation bound
- COOLDOWN, 2, speed pulses after a successful shot before the next shot is accepted

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- pulse_projSpeed  in  1  single-cycle movement tick
- shoot  in  1  fire request (level; rising edge acts)
- hit_vec  in  N_PROJ  bit i = slot i collided this cycle
- playerX  in  X_W  shooter left x
- playerY  in  Y_W  shooter y
- playerW  in  X_W  shooter width
- proj_x  out  N_PROJ*X_W  slot i at [i*X_W +: X_W]
- proj_y  out  N_PROJ*Y_W  slot i at [i*Y_W +: Y_W]
- proj_active  out  N_PROJ  slot live flags
- shot_fired  out  1  one-cycle pulse: spawn accepted
- shot_blocked  out  1  one-cycle pulse: edge rejected (pool full or cooldown)
- pool_full  out  1  all proj_active bits set

## Operation
- Registered state per slot: active, x, y. An inactive slot always reads x=0, y=0.
- Edge detect: shoot_d register; fire_req = shoot & ~shoot_d.
- Spawn, when fire_req, cooldown==0 and a free slot exists:
  - slot = lowest index with active=0, judged on the pre-cycle state.
  - x = playerX + (playerW>>1), computed at X_W+1 bits and saturated to X_MAX.
  - y = playerY.
  - active=1; shot_fired=1; cooldown loads COOLDOWN.
- fire_req with the pool full or cooldown≠0: shot_blocked=1. The request is dropped, not queued.
- Move, on pulse_projSpeed, for each active slot not hit this cycle:
  - DIR_UP=1: if y < Y_MIN+STEP, retire; else y -= STEP.
  - DIR_UP=0: if y+STEP > Y_MAX, retire (compare at Y_W+1 bits); else y += STEP.
- Retire: active=0, x=0, y=0.
- Hit: hit_vec[i] on an active slot retires it. A hit takes priority over a move. A hit on an inactive slot is ignored.
- Cooldown: decrements by 1 on each pulse_projSpeed while nonzero. It is not affected by hits.
- Simultaneous events:
  - A slot freed this cycle (hit or retire) is not spawnable until the next cycle.
  - A newly spawned slot does not move in its spawn cycle, even if pulse_projSpeed is high.
  - Spawn in slot j together with a hit on slot k≠j: both apply.

## Timing
- Every output is registered. Events sampled at edge t appear on outputs after edge t (latency 1).
- shot_fired and shot_blocked are high for exactly the one cycle after the sampling edge.
- Reset (rst=0 at an edge), applied the same edge:
  - all active, x, y = 0
  - cooldown = 0
  - shot_fired, shot_blocked = 0
  - shoot_d = 1, so a shoot held through reset does not fire on release.
- Reset mid-flight discards all projectiles. It has no effect on inputs.
- pool_full is derived from the registered proj_active and updates in the same cycle as proj_active.

## Test plan
- Spawn and move (defaults): playerX=449, playerY=450, playerW=30, shoot 0→1 → next cycle slot0 active, x=464, y=450, shot_fired=1. Then one pulse_projSpeed → y=446. Shoot held high → no further spawn.
- Cooldown: fire, then a second shoot edge before 2 pulses → shot_blocked=1, no new slot. After 2 pulses, an edge → slot1 spawns.
- Pool full: three accepted shots → proj_active=3'b111, pool_full=1. Fourth edge → shot_blocked=1, state unchanged.
- Hit and reuse: hit_vec=3'b010 together with pulse → slot1 cleared to 0/0 while slots 0 and 2 move by 4. The next accepted shot lands in slot1.
- Edge retire and saturation: slot y=3 with pulse → retired. DIR_UP=0, y=477, pulse → retired. playerX=630, playerW=30 → spawn x=639.
- Reset mid-operation: rst=0 for one edge with two live slots and shoot held high → all outputs 0. Releasing rst with shoot still high → no spawn.
